prog_loader_mem: RTL and testbench
==================================

# prog_loader_mem

Parametrised, loadable program memory for the single-cycle core. It replaces the fixed 31-word, combinational-read, file-initialised program store. Changes from that store:
- depth, address width and instruction width are parameters;
- read data is registered (one-cycle latency);
- a valid/ready streaming load port lets a boot loader or testbench write a new program at run time.

A small state machine tracks whether memory holds a complete program and gates instruction delivery to the core.

## Interface
Parameters:
- Psize, 5, address width
- Isize, 20, instruction width
- Depth, 32, number of words; must satisfy 2 ≤ Depth ≤ 2^Psize
- INIT_FILE, "prog.hex", hex image used when PROG_READMEM_EN is defined

Ports:
- Clock  in  1  single clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- ProgAddress  in  Psize  fetch address
- ProgEnable  in  1  fetch request this cycle
- I  out  Isize  registered instruction
- IValid  out  1  I holds data for the previous cycle's request
- ProgReady  out  1  memory holds a complete program
- ProgWords  out  Psize+1  number of words in the current program
- LoadStart  in  1  begin a new load at address 0
- LoadData  in  Isize  load word
- LoadValid  in  1  LoadData valid
- LoadLast  in  1  current load word is the final word
- LoadReady  out  1  load port accepts a word
- LoadError  out  1  sticky flag: overrun, more than Depth words sent without LoadLast

## Operation
- The state machine has three states, defined in the package as prog_state_t:
  - PROG_EMPTY: no program. ProgReady=0.
  - PROG_LOADING: accepting words. ProgReady=0.
  - PROG_READY: program valid. ProgReady=1.
- LoadStart in any state moves to PROG_LOADING, clears the write pointer WrPtr to 0 and clears LoadError.
- LoadReady = (state==PROG_LOADING) && !LoadStart. A beat presented in the same cycle as LoadStart is not accepted.
- A word is accepted when LoadValid && LoadReady. It is written to mem[WrPtr], then WrPtr increments.
- If the accepted word also has LoadLast:
  - ProgWords <= WrPtr+1;
  - state moves to PROG_READY.
- If the word accepted at WrPtr==Depth-1 does not have LoadLast:
  - the word is still written;
  - LoadError <= 1;
  - state moves to PROG_EMPTY and ProgWords <= 0.
- Fetch, when ProgEnable && state==PROG_READY:
  - if ProgAddress < ProgWords, then I <= mem[ProgAddress];
  - otherwise I <= 0 (all-zero word = NOP);
  - IValid <= 1 in both cases.
- In any other cycle IValid <= 0 and I holds its previous value.
- Memory contents persist across loads and resets. Only words that are written change.

## Timing
- Reset values:
  - I=0, IValid=0, LoadError=0, WrPtr=0;
  - LoadReady=0, because state is never PROG_LOADING out of reset;
  - state, ProgReady and ProgWords are set per Configuration.
- Read latency is 1 cycle: address in cycle n gives I and IValid in cycle n+1.
- A load word accepted in cycle n is readable from cycle n+1. Reads are possible only once the state is PROG_READY, i.e. the cycle after LoadLast is accepted.
- LoadStart while in PROG_READY stops fetches. IValid=0 from the next cycle onward.
- nReset asserted mid-load aborts the load immediately. A partially loaded image is not repaired.
- Load throughput: one word per cycle while LoadValid stays high.

## Configuration
PROG_READMEM_EN:
- Defined:
  - memory is initialised by $readmemh(INIT_FILE) at elaboration;
  - reset state is PROG_READY;
  - ProgWords resets to Depth;
  - the core may fetch from the first cycle after reset.
- Undefined:
  - no file is read and memory contents are unknown;
  - reset state is PROG_EMPTY, ProgWords resets to 0 and ProgReady=0;
  - a load must complete before any fetch.

## Structure
- Package prog_pkg holds:
  - the prog_state_t enum (PROG_EMPTY, PROG_LOADING, PROG_READY);
  - the PROG_NOP constant (all-zero);
  - the default Psize, Isize and Depth values.
- Sub-module prog_ram contains the Depth x Isize array:
  - one synchronous write port;
  - one registered read port;
  - the $readmemh initial block under PROG_READMEM_EN.
- The top level contains the FSM, WrPtr, ProgWords, the range check and the handshake logic.

## Test plan
- Reset with PROG_READMEM_EN defined and INIT_FILE word 3 = 20'hABCDE; fetch address 3 -> next cycle I=20'hABCDE, IValid=1, ProgReady=1.
- Reset without the macro; LoadStart, then 4 words 20'h00001..20'h00004 with LoadLast on the 4th -> ProgWords=4, ProgReady=1; fetch address 2 -> I=20'h00003; fetch address 7 -> I=0, IValid=1.
- Depth=8; send 8 words without LoadLast -> LoadError=1, state PROG_EMPTY; fetch -> IValid=0; a subsequent LoadStart -> LoadError=0.
- During a load, LoadStart asserted together with LoadValid carrying 20'h12345 -> beat not accepted, WrPtr=0; the next accepted word lands at address 0.
- nReset pulsed after 2 of 5 words (macro undefined) -> all outputs return to reset values, ProgReady=0, LoadReady=0.
- LoadValid toggled every other cycle during a 6-word load -> exactly 6 writes, correct addresses, ProgWords=6.

Source files
------------

// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_pkg
//  Description : Shared types and defaults for the loadable program memory.
//                Holds the load/ready state encoding, the NOP instruction
//                word and the default geometry (address width, instruction
//                width, depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_pkg;

    localparam int PROG_PSIZE = 5;
    localparam int PROG_ISIZE = 20;
    localparam int PROG_DEPTH = 32;

    // All-zero word; the core treats it as a no-operation.
    localparam logic [PROG_ISIZE-1:0] PROG_NOP = '0;

    typedef enum logic [1:0] {
        PROG_EMPTY   = 2'd0,
        PROG_LOADING = 2'd1,
        PROG_READY   = 2'd2
    } prog_state_t;

endpackage : prog_pkg
`default_nettype wire

// File: rtl/prog_ram.sv
`default_nettype none
// ============================================================================
//  Module      : prog_ram
//  Description : DEPTH x DATA_W program array with one synchronous write port
//                and one registered read port. When i_rd_hit is low the read
//                register loads the NOP word instead of array data. The read
//                register holds its value in cycles without i_rd_en.
//  Ports       : clk, rst_n        - clock, async active-low reset (read reg)
//                i_wr_en/addr/data - write port
//                i_rd_en/hit/addr  - read request, in-range flag, address
//                o_rd_data         - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_ram
    import prog_pkg::*;
#(
    parameter int    IDX_W     = 5,
    parameter int    DATA_W    = PROG_ISIZE,
    parameter int    DEPTH     = PROG_DEPTH,
    parameter string INIT_FILE = "prog.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_rd_hit,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Array contents are deliberately not reset: a program survives reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_hit ? r_mem[i_rd_addr] : DATA_W'(PROG_NOP);
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : prog_ram
`default_nettype wire

// File: rtl/prog_loader_mem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_mem
//  Description : Loadable program memory for the single-cycle core. A
//                valid/ready load port streams a program in from address 0;
//                a small FSM tracks EMPTY / LOADING / READY and only allows
//                fetches once a complete program is present. Fetches past the
//                end of the program return the NOP word. Read latency is one
//                cycle.
//                Macro PROG_READMEM_EN: array preloaded from INIT_FILE, reset
//                state READY with ProgWords = Depth.
//  Ports       : Clock, nReset                  - clock, async active-low rst
//                ProgAddress, ProgEnable        - fetch request
//                I, IValid                      - registered instruction
//                ProgReady, ProgWords           - program status
//                LoadStart/Data/Valid/Last      - load stream in
//                LoadReady, LoadError           - load stream status
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_mem
    import prog_pkg::*;
#(
    parameter int    Psize     = PROG_PSIZE,
    parameter int    Isize     = PROG_ISIZE,
    parameter int    Depth     = PROG_DEPTH,
    parameter string INIT_FILE = "prog.hex"
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [Psize-1:0] ProgAddress,
    input  logic             ProgEnable,
    output logic [Isize-1:0] I,
    output logic             IValid,
    output logic             ProgReady,
    output logic [Psize:0]   ProgWords,
    input  logic             LoadStart,
    input  logic [Isize-1:0] LoadData,
    input  logic             LoadValid,
    input  logic             LoadLast,
    output logic             LoadReady,
    output logic             LoadError
);

    localparam int             c_idx_w    = $clog2(Depth);
    localparam logic [Psize:0] c_last_ptr = (Psize+1)'(Depth - 1);

`ifdef PROG_READMEM_EN
    localparam prog_state_t    c_rst_state = PROG_READY;
    localparam logic [Psize:0] c_rst_words = (Psize+1)'(Depth);
`else
    localparam prog_state_t    c_rst_state = PROG_EMPTY;
    localparam logic [Psize:0] c_rst_words = '0;
`endif

    prog_state_t    r_state;
    prog_state_t    w_next_state;
    logic [Psize:0] r_wr_ptr;
    logic [Psize:0] r_prog_words;
    logic           r_load_error;
    logic           r_ivalid;

    logic           w_load_ready;
    logic           w_accept;
    logic           w_overrun;
    logic           w_fetch;
    logic           w_in_range;

    // A beat coinciding with LoadStart belongs to no program and is dropped.
    assign w_load_ready = (r_state == PROG_LOADING) && !LoadStart;
    assign w_accept     = LoadValid && w_load_ready;
    assign w_overrun    = w_accept && !LoadLast && (r_wr_ptr == c_last_ptr);
    // LoadStart gates the fetch in its own cycle so IValid drops immediately.
    assign w_fetch      = ProgEnable && (r_state == PROG_READY) && !LoadStart;
    assign w_in_range   = {1'b0, ProgAddress} < r_prog_words;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (LoadStart) begin
            w_next_state = PROG_LOADING;
        end else if (w_accept && LoadLast) begin
            w_next_state = PROG_READY;
        end else if (w_overrun) begin
            w_next_state = PROG_EMPTY;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr     <= '0;
            r_prog_words <= c_rst_words;
            r_load_error <= 1'b0;
        end else if (LoadStart) begin
            r_wr_ptr     <= '0;
            r_load_error <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (LoadLast) begin
                r_prog_words <= r_wr_ptr + 1'b1;
            end else if (r_wr_ptr == c_last_ptr) begin
                r_prog_words <= '0;
                r_load_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_ivalid <= 1'b0;
        end else begin
            r_ivalid <= w_fetch;
        end
    end

    prog_ram #(
        .IDX_W     (c_idx_w),
        .DATA_W    (Isize),
        .DEPTH     (Depth),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk       (Clock),
        .rst_n     (nReset),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr[c_idx_w-1:0]),
        .i_wr_data (LoadData),
        .i_rd_en   (w_fetch),
        .i_rd_hit  (w_in_range),
        .i_rd_addr (ProgAddress[c_idx_w-1:0]),
        .o_rd_data (I)
    );

    assign IValid    = r_ivalid;
    assign ProgReady = (r_state == PROG_READY);
    assign ProgWords = r_prog_words;
    assign LoadReady = w_load_ready;
    assign LoadError = r_load_error;

endmodule : prog_loader_mem
`default_nettype wire

// File: tb/tb_prog_loader_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader_mem
//  Description : Directed self-checking bench for prog_loader_mem, built with
//                Depth=8 so the overrun boundary is short. Default build
//                (PROG_READMEM_EN undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader_mem;

    localparam int c_psize = 5;
    localparam int c_isize = 20;
    localparam int c_depth = 8;

    logic               Clock = 1'b0;
    logic               nReset = 1'b0;
    logic [c_psize-1:0] ProgAddress = '0;
    logic               ProgEnable = 1'b0;
    logic [c_isize-1:0] I;
    logic               IValid;
    logic               ProgReady;
    logic [c_psize:0]   ProgWords;
    logic               LoadStart = 1'b0;
    logic [c_isize-1:0] LoadData = '0;
    logic               LoadValid = 1'b0;
    logic               LoadLast = 1'b0;
    logic               LoadReady;
    logic               LoadError;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    prog_loader_mem #(
        .Psize (c_psize),
        .Isize (c_isize),
        .Depth (c_depth)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .ProgAddress (ProgAddress),
        .ProgEnable  (ProgEnable),
        .I           (I),
        .IValid      (IValid),
        .ProgReady   (ProgReady),
        .ProgWords   (ProgWords),
        .LoadStart   (LoadStart),
        .LoadData    (LoadData),
        .LoadValid   (LoadValid),
        .LoadLast    (LoadLast),
        .LoadReady   (LoadReady),
        .LoadError   (LoadError)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        #1;
        checks++;
        if ({I, IValid, ProgReady, ProgWords, LoadReady, LoadError} !==
            {20'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: I=%h IValid=%b Ready=%b Words=%0d LReady=%b LErr=%b, required all zero",
                     I, IValid, ProgReady, ProgWords, LoadReady, LoadError);
        end
        tick;
        nReset = 1'b1;
        ProgEnable = 1'b1;
        ProgAddress = 5'd0;
        tick;
        ProgEnable = 1'b0;
        checks++;
        if (IValid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_when_empty: IValid=%b required 0", IValid);
        end
    endtask

    task automatic test_load4;
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        #1;
        checks++;
        if (LoadReady !== 1'b1 || ProgReady !== 1'b0) begin
            errors++;
            $display("FAIL loading_state: LoadReady=%b ProgReady=%b required 1/0", LoadReady, ProgReady);
        end
        for (int k = 0; k < 4; k++) begin
            LoadValid = 1'b1;
            LoadData  = 20'(k + 1);
            LoadLast  = (k == 3);
            tick;
        end
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        checks++;
        if (ProgWords !== 6'd4 || ProgReady !== 1'b1 || LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL load4_status: Words=%0d Ready=%b LReady=%b required 4/1/0", ProgWords, ProgReady, LoadReady);
        end
        ProgEnable  = 1'b1;
        ProgAddress = 5'd2;
        tick;
        checks++;
        if (I !== 20'h00003 || IValid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_addr2: I=%h IValid=%b required 00003/1", I, IValid);
        end
        ProgAddress = 5'd7;
        tick;
        checks++;
        if (I !== 20'h00000 || IValid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_out_of_range: I=%h IValid=%b required 00000/1", I, IValid);
        end
        ProgAddress = 5'd3;
        tick;
        ProgEnable = 1'b0;
        tick;
        checks++;
        if (I !== 20'h00004 || IValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: I=%h IValid=%b required 00004/0", I, IValid);
        end
    endtask

    task automatic test_overrun;
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        for (int k = 0; k < c_depth; k++) begin
            LoadValid = 1'b1;
            LoadData  = 20'h00100 + 20'(k);
            tick;
        end
        LoadValid = 1'b0;
        checks++;
        if (LoadError !== 1'b1 || ProgReady !== 1'b0 || ProgWords !== 6'd0 || LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL overrun_status: LErr=%b Ready=%b Words=%0d LReady=%b required 1/0/0/0",
                     LoadError, ProgReady, ProgWords, LoadReady);
        end
        ProgEnable  = 1'b1;
        ProgAddress = 5'd0;
        tick;
        ProgEnable = 1'b0;
        checks++;
        if (IValid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_after_overrun: IValid=%b required 0", IValid);
        end
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        checks++;
        if (LoadError !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: LoadError=%b required 0", LoadError);
        end
    endtask

    // Entered in PROG_LOADING with the pointer at 0.
    task automatic test_start_collision;
        for (int k = 0; k < 2; k++) begin
            LoadValid = 1'b1;
            LoadData  = 20'h000A0 + 20'(k);
            tick;
        end
        LoadStart = 1'b1;
        LoadData  = 20'h12345;
        #1;
        checks++;
        if (LoadReady !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_start: LoadReady=%b required 0", LoadReady);
        end
        tick;
        LoadStart = 1'b0;
        LoadData  = 20'h0000F;
        LoadLast  = 1'b1;
        tick;
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        checks++;
        if (ProgWords !== 6'd1 || ProgReady !== 1'b1) begin
            errors++;
            $display("FAIL collision_words: Words=%0d Ready=%b required 1/1", ProgWords, ProgReady);
        end
        ProgEnable  = 1'b1;
        ProgAddress = 5'd0;
        tick;
        checks++;
        if (I !== 20'h0000F || IValid !== 1'b1) begin
            errors++;
            $display("FAIL collision_addr0: I=%h IValid=%b required 0000F/1", I, IValid);
        end
        ProgAddress = 5'd1;
        tick;
        checks++;
        if (I !== 20'h00000 || IValid !== 1'b1) begin
            errors++;
            $display("FAIL collision_addr1: I=%h IValid=%b required 00000/1", I, IValid);
        end
        ProgAddress = 5'd0;
        tick;
        ProgEnable = 1'b0;
    endtask

    // I holds 0000F on entry; reset must clear it.
    task automatic test_reset_midload;
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        for (int k = 0; k < 2; k++) begin
            LoadValid = 1'b1;
            LoadData  = 20'h00050 + 20'(k);
            tick;
        end
        nReset = 1'b0;
        #1;
        checks++;
        if ({I, IValid, ProgReady, ProgWords, LoadReady, LoadError} !==
            {20'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midload_reset: I=%h IValid=%b Ready=%b Words=%0d LReady=%b LErr=%b, required all zero",
                     I, IValid, ProgReady, ProgWords, LoadReady, LoadError);
        end
        LoadValid = 1'b0;
        tick;
        nReset = 1'b1;
        tick;
        checks++;
        if (LoadReady !== 1'b0 || ProgReady !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: LoadReady=%b ProgReady=%b required 0/0", LoadReady, ProgReady);
        end
    endtask

    task automatic test_throttled;
        int idx = 0;
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        for (int c = 0; c < 12; c++) begin
            LoadValid = (c % 2 == 1);
            LoadData  = 20'h00060 + 20'(idx);
            LoadLast  = (idx == 5);
            tick;
            if (c % 2 == 1) idx++;
        end
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
        checks++;
        if (ProgWords !== 6'd6 || ProgReady !== 1'b1) begin
            errors++;
            $display("FAIL throttled_words: Words=%0d Ready=%b required 6/1", ProgWords, ProgReady);
        end
        ProgEnable = 1'b1;
        for (int a = 0; a < 7; a++) begin
            logic [19:0] exp;
            exp = (a < 6) ? 20'h00060 + 20'(a) : 20'h00000;
            ProgAddress = 5'(a);
            tick;
            checks++;
            if (I !== exp || IValid !== 1'b1) begin
                errors++;
                $display("FAIL throttled_fetch[%0d]: I=%h IValid=%b required %h/1", a, I, IValid, exp);
            end
        end
        ProgEnable = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_load4;
        test_overrun;
        test_start_collision;
        test_reset_midload;
        test_throttled;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prog_loader_mem
`default_nettype wire
